instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Program store and program counter feeding the bit_serial datapath with 3-bit instructions. It holds a small writable program, presents the instruction at the current PC combinationally, and advances the PC on the datapath's pc-increment request. It replaces the ad-hoc mem/pc pair currently built in the bench, and adds a load port, a run/idle control and wrap reporting so the whole datapath plus program can be integrated at top level.

Parameters:
IW, 3, instruction width (must match bit_serial i_data_instruction)
AW, 3, address/PC width; DEPTH = 2**AW entries
RESET_PC, 0, PC value after reset and on leaving RUN

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-low (0 = reset)
i_load_en  in  1  program write strobe
i_load_addr  in  AW  write address
i_load_data  in  IW  write data
i_run  in  1  level: 1 = execute program, 0 = idle
i_con_pcincr  in  1  PC advance request from bit_serial o_con_pcincr
o_data_instruction  out  IW  instruction to bit_serial
o_pc  out  AW  current PC
o_running  out  1  1 while state = RUN
o_wrap  out  1  one-cycle pulse when PC wraps DEPTH-1 -> 0
o_load_err  out  1  one-cycle pulse on a rejected write
o_pass_count  out  8  completed program passes, saturating

Behaviour:
- Reset (i_rst=0, async): state IDLE, PC=RESET_PC, all memory entries = OP_STALL (3'b001), o_running=0, o_wrap=0, o_load_err=0, o_pass_count=0. Reset mid-RUN aborts immediately; no partial state survives.
- States: IDLE, RUN.
- IDLE: i_load_en=1 writes mem[i_load_addr] <= i_load_data at the edge. i_run=1 -> RUN at the next edge. If both in the same cycle: write commits and state -> RUN on that edge; the first RUN-cycle fetch sees the written data. i_con_pcincr ignored.
- RUN: i_con_pcincr=1 -> PC <= PC+1 at the edge. At PC=DEPTH-1, PC <= 0, o_wrap=1 for the following cycle, o_pass_count += 1 (holds at 255). i_load_en=1 in RUN: no write, o_load_err=1 for the following cycle. i_run=0 -> IDLE at the next edge and PC <= RESET_PC; an i_con_pcincr in that same cycle is discarded (no wrap, no count).
- o_data_instruction: combinational. RUN: mem[PC] (zero latency, same cycle as PC). IDLE: forced OP_STALL so the datapath never executes while idle or loading.
- o_pc is the registered PC; o_running = (state==RUN); no combinational path from any input to o_running, o_wrap or o_load_err.
- Writes are synchronous, single-port; the read is asynchronous. A write to the address being read is visible the cycle after the write edge.
- o_pass_count cleared only by reset.

Decomposition:
- Shared package bs_pkg: IW, opcode constants (OP_RESET 3'b000, OP_STALL 3'b001, OP_MULT_YD 3'b010, OP_MULT_X1D 3'b011, OP_ADD 3'b100, OP_WAIT_SW 3'b110, OP_INIT 3'b111), fetch state enum fetch_state_t {IDLE, RUN}. bit_serial migrates to the same constants.
- Sub-module prog_mem: DEPTH x IW register file, sync write, async read, async active-low reset to OP_STALL. instr_fetch holds the FSM, PC, pulse and counter logic.

Test Plan:
- Reset then idle: i_rst=0 for 2 cycles, release -> o_pc=0, o_running=0, o_data_instruction=3'b001, o_pass_count=0.
- Load 000,111,001,010,001,011,100,110 to addr 0..7, raise i_run -> o_running=1 next edge, o_data_instruction=3'b000 at PC 0; pcincr once -> 3'b111.
- Continuous pcincr for 8 cycles in RUN -> PC 0..7 then 0; o_wrap high exactly one cycle after the 7->0 edge; o_pass_count=1; after 2048 increments o_pass_count=255 (saturated).
- i_load_en with addr 2, data 3'b101 during RUN -> o_load_err pulse 1 cycle, mem[2] still 3'b001 on a later read.
- i_run dropped at PC=5 with pcincr=1 in the same cycle -> IDLE, o_pc=0, o_wrap=0, count unchanged, output 3'b001.
- Assert i_rst mid-RUN at PC=4 (async, between edges) -> outputs return to reset values immediately; memory reads 3'b001 everywhere after release.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared constants for the bit_serial datapath and its instruction fetch unit:
// opcode encodings, instruction width and the fetch FSM state type.
package bs_pkg;

  localparam int IW     = 3;
  localparam int PASS_W = 8;

  localparam logic [IW-1:0] OP_RESET    = 3'b000;
  localparam logic [IW-1:0] OP_STALL    = 3'b001;
  localparam logic [IW-1:0] OP_MULT_YD  = 3'b010;
  localparam logic [IW-1:0] OP_MULT_X1D = 3'b011;
  localparam logic [IW-1:0] OP_ADD      = 3'b100;
  localparam logic [IW-1:0] OP_WAIT_SW  = 3'b110;
  localparam logic [IW-1:0] OP_INIT     = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Increment that sticks at the all-ones value instead of rolling over.
  function automatic logic [PASS_W-1:0] sat_inc(input logic [PASS_W-1:0] value);
    return (value == {PASS_W{1'b1}}) ? value : value + PASS_W'(1);
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x IW register file with synchronous write and
// asynchronous read; every entry resets to OP_STALL.
module prog_mem
  import bs_pkg::*;
#(
  parameter int IW = 3,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  localparam int DEPTH = 2 ** AW;

  logic [IW-1:0]    mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_sel;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
    end
  endgenerate

  // Reset must clear every entry, so this cannot map onto a block RAM.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= IW'(OP_STALL);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= wr_data;
        end
      end
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Program counter and run/idle control feeding bit_serial; owns the program
// store and reports wraps, rejected writes and completed passes.
module instr_fetch
  import bs_pkg::*;
#(
  parameter int IW       = 3,
  parameter int AW       = 3,
  parameter int RESET_PC = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [IW-1:0] i_load_data,
  input  logic          i_run,
  input  logic          i_con_pcincr,
  output logic [IW-1:0] o_data_instruction,
  output logic [AW-1:0] o_pc,
  output logic          o_running,
  output logic          o_wrap,
  output logic          o_load_err,
  output logic [7:0]    o_pass_count
);

  localparam int DEPTH = 2 ** AW;

  fetch_state_t      state_reg;
  logic [AW-1:0]     pc_reg;
  logic              wrap_reg;
  logic              load_err_reg;
  logic [PASS_W-1:0] pass_count_reg;

  logic              mem_wr_en;
  logic [IW-1:0]     mem_rd_data;
  logic              pc_at_last;

  // Program is only writable while idle so a running program never changes under the PC.
  assign mem_wr_en  = i_load_en && (state_reg == IDLE);
  assign pc_at_last = (pc_reg == AW'(DEPTH - 1));

  prog_mem #(
    .IW (IW),
    .AW (AW)
  ) u_prog_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (mem_wr_en),
    .wr_addr (i_load_addr),
    .wr_data (i_load_data),
    .rd_addr (pc_reg),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= IDLE;
      pc_reg         <= AW'(RESET_PC);
      wrap_reg       <= 1'b0;
      load_err_reg   <= 1'b0;
      pass_count_reg <= '0;
    end else begin
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_run) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          load_err_reg <= i_load_en;
          // Leaving RUN wins over a same-cycle increment, so no wrap or count.
          if (!i_run) begin
            state_reg <= IDLE;
            pc_reg    <= AW'(RESET_PC);
          end else if (i_con_pcincr) begin
            pc_reg <= pc_reg + AW'(1);
            if (pc_at_last) begin
              wrap_reg       <= 1'b1;
              pass_count_reg <= sat_inc(pass_count_reg);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          pc_reg    <= AW'(RESET_PC);
        end
      endcase
    end
  end

  assign o_data_instruction = (state_reg == RUN) ? mem_rd_data : IW'(OP_STALL);
  assign o_pc               = pc_reg;
  assign o_running          = (state_reg == RUN);
  assign o_wrap             = wrap_reg;
  assign o_load_err         = load_err_reg;
  assign o_pass_count       = pass_count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_instr_fetch;

  logic       i_clk;
  logic       i_rst;
  logic       i_load_en;
  logic [2:0] i_load_addr;
  logic [2:0] i_load_data;
  logic       i_run;
  logic       i_con_pcincr;
  logic [2:0] o_data_instruction;
  logic [2:0] o_pc;
  logic       o_running;
  logic       o_wrap;
  logic       o_load_err;
  logic [7:0] o_pass_count;

  typedef struct {
    string      name;
    logic [2:0] pc;
    logic [2:0] instr;
    logic       running;
    logic       wrap;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [2:0] prog [8];

  instr_fetch #(
    .IW       (3),
    .AW       (3),
    .RESET_PC (0)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_load_en          (i_load_en),
    .i_load_addr        (i_load_addr),
    .i_load_data        (i_load_data),
    .i_run              (i_run),
    .i_con_pcincr       (i_con_pcincr),
    .o_data_instruction (o_data_instruction),
    .o_pc               (o_pc),
    .o_running          (o_running),
    .o_wrap             (o_wrap),
    .o_load_err         (o_load_err),
    .o_pass_count       (o_pass_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive(input logic run, input logic incr, input logic load,
                       input logic [2:0] addr, input logic [2:0] data);
    i_run        = run;
    i_con_pcincr = incr;
    i_load_en    = load;
    i_load_addr  = addr;
    i_load_data  = data;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [2:0] pc, input logic [2:0] instr,
                            input logic running, input logic wrap, input logic err,
                            input logic [7:0] cnt);
    exp_t e;
    e.name = name; e.pc = pc; e.instr = instr; e.running = running;
    e.wrap = wrap; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation is consumed per falling edge, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (o_pc !== e.pc || o_data_instruction !== e.instr || o_running !== e.running ||
            o_wrap !== e.wrap || o_load_err !== e.err || o_pass_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got pc=%0d instr=%b run=%b wrap=%b err=%b cnt=%0d, want pc=%0d instr=%b run=%b wrap=%b err=%b cnt=%0d",
                   e.name, o_pc, o_data_instruction, o_running, o_wrap, o_load_err, o_pass_count,
                   e.pc, e.instr, e.running, e.wrap, e.err, e.cnt);
        end else begin
          $display("vec %0d %s ok: pc=%0d instr=%b run=%b wrap=%b err=%b cnt=%0d",
                   n_vec, e.name, o_pc, o_data_instruction, o_running, o_wrap, o_load_err, o_pass_count);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    prog[0] = 3'b000; prog[1] = 3'b111; prog[2] = 3'b001; prog[3] = 3'b010;
    prog[4] = 3'b001; prog[5] = 3'b011; prog[6] = 3'b100; prog[7] = 3'b110;

    i_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    repeat (2) @(posedge i_clk);
    #1;
    expect_now("reset_held", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge i_clk);
    tick();
    i_rst = 1'b1;
    tick();
    expect_now("reset_idle", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd0);

    // Load 1..7 while idle; output stays forced to stall.
    for (int a = 1; a < 8; a++) begin
      drive(1'b0, 1'b0, 1'b1, 3'(a), prog[a]);
      tick();
      expect_now("load_idle", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Write addr 0 and start in the same cycle: first fetch sees the new data.
    drive(1'b1, 1'b0, 1'b1, 3'd0, prog[0]);
    tick();
    expect_now("run_first_fetch", 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0);

    for (int a = 1; a < 8; a++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
      tick();
      expect_now("incr", 3'(a), prog[a], 1'b1, 1'b0, 1'b0, 8'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    tick();
    expect_now("wrap_7_to_0", 3'd0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd1);

    // Rejected write while running.
    drive(1'b1, 1'b0, 1'b1, 3'd2, 3'b101);
    tick();
    expect_now("load_err_pulse", 3'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd1);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    tick();
    expect_now("load_err_clear", 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd1);

    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    tick();
    tick();
    expect_now("mem2_unchanged", 3'd2, 3'b001, 1'b1, 1'b0, 1'b0, 8'd1);
    repeat (3) tick();
    expect_now("at_pc5", 3'd5, 3'b011, 1'b1, 1'b0, 1'b0, 8'd1);

    // Drop run with a same-cycle increment: increment is discarded.
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    tick();
    expect_now("run_drop_pc5", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd1);
    tick();
    expect_now("idle_ignores_incr", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd1);

    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    tick();
    expect_now("rerun", 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd1);
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    repeat (7) tick();
    expect_now("at_pc7", 3'd7, 3'b110, 1'b1, 1'b0, 1'b0, 8'd1);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    tick();
    expect_now("run_drop_pc7_no_wrap", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd1);

    // 2048 increments = 256 wraps on top of 1: counter saturates at 255.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    repeat (2048) tick();
    expect_now("pass_count_saturated", 3'd0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd255);
    repeat (8) tick();
    expect_now("pass_count_holds", 3'd0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd255);
    repeat (4) tick();
    expect_now("at_pc4", 3'd4, 3'b001, 1'b1, 1'b0, 1'b0, 8'd255);

    // Asynchronous reset between edges while running.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    @(negedge i_clk);
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    #1;
    expect_now("async_reset_mid_run", 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge i_clk);
    tick();
    i_rst = 1'b1;
    tick();
    expect_now("post_reset_run", 3'd0, 3'b001, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    for (int a = 1; a < 8; a++) begin
      tick();
      expect_now("mem_reset_stall", 3'(a), 3'b001, 1'b1, 1'b0, 1'b0, 8'd0);
    end

    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    @(negedge i_clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
